// File: rtl/dm_cache_system.sv
// Direct-mapped write-back/write-allocate cache (256 x 32-bit lines) with its own word-addressed backing memory.
// One request at a time; ready is held in DONE until the CPU drops its request.
module dm_cache_system #(
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic [7:0]  cpu_data_out,
    output logic        ready
);

    localparam int          MAW      = $clog2(MEM_WORDS);
    localparam logic [15:0] LAT_LAST = 16'(MEM_LATENCY - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] COMPARE    = 3'd1;
    localparam logic [2:0] WRITE_BACK = 3'd2;
    localparam logic [2:0] ALLOCATE   = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    logic [2:0]  state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wr;

    logic [255:0] valid;
    logic [255:0] dirty;
    logic [21:0]  tag_arr  [256];
    logic [31:0]  data_arr [256];

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] lat_cnt;

    logic [7:0]     idx;
    logic [21:0]    req_tag;
    logic [1:0]     off;
    logic [MAW-1:0] req_widx;
    logic [MAW-1:0] wb_widx;
    logic [31:0]    mem_wdata;
    logic           hit;
    logic           evict;
    logic           mem_read;
    logic           mem_write;

    assign idx       = req_addr[9:2];
    assign req_tag   = req_addr[31:10];
    assign off       = req_addr[1:0];
    assign req_widx  = req_addr[MAW+1:2];
    // Victim word address; the line is untouched until ALLOCATE so the stored tag is still the old one.
    assign wb_widx   = MAW'({tag_arr[idx], idx});
    assign mem_wdata = data_arr[idx];
    assign hit       = valid[idx] && (tag_arr[idx] == req_tag);
    assign evict     = valid[idx] && dirty[idx];
    assign ready     = (state == DONE);

    // Requests drop in the cycle mem_ready is seen so read and write never overlap.
    assign mem_write = ((state == COMPARE) && !hit && evict) ||
                       ((state == WRITE_BACK) && !mem_ready);
    assign mem_read  = ((state == COMPARE) && !hit && !evict) ||
                       ((state == WRITE_BACK) && mem_ready) ||
                       ((state == ALLOCATE) && !mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b0;
            lat_cnt   <= '0;
            mem_rdata <= '0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            mem_ready <= 1'b0;
            if (mem_read || mem_write) begin
                if (lat_cnt == LAT_LAST) begin
                    mem_ready <= 1'b1;
                    lat_cnt   <= '0;
                    if (mem_read) begin
                        mem_rdata <= mem[req_widx];
                    end
                end else begin
                    lat_cnt <= lat_cnt + 16'd1;
                end
            end
            if ((state == WRITE_BACK) && mem_ready) begin
                mem[wb_widx] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cpu_data_out <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_wr       <= 1'b0;
            valid        <= '0;
            dirty        <= '0;
            for (int i = 0; i < 256; i++) begin
                tag_arr[i]  <= '0;
                data_arr[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        req_addr  <= cpu_address;
                        req_wdata <= cpu_wdata;
                        req_wr    <= cpu_write;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_wr) begin
                            data_arr[idx] <= req_wdata;
                            dirty[idx]    <= 1'b1;
                        end else begin
                            cpu_data_out <= data_arr[idx][{off, 3'b000} +: 8];
                        end
                        state <= DONE;
                    end else if (evict) begin
                        state <= WRITE_BACK;
                    end else begin
                        state <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem_ready) begin
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        valid[idx]   <= 1'b1;
                        tag_arr[idx] <= req_tag;
                        if (req_wr) begin
                            data_arr[idx] <= req_wdata;
                            dirty[idx]    <= 1'b1;
                        end else begin
                            data_arr[idx] <= mem_rdata;
                            dirty[idx]    <= 1'b0;
                            cpu_data_out  <= mem_rdata[{off, 3'b000} +: 8];
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!cpu_read && !cpu_write) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_system.sv
// Directed bench for dm_cache_system: latencies, byte select, dirty eviction, held request, reset abort.
module tb_dm_cache_system;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [7:0]  cpu_data_out;
    logic        ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data = '0;
    int          rdy_cnt = 0;

    always #5 clk = ~clk;

    dm_cache_system dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_data_out (cpu_data_out),
        .ready        (ready)
    );

    always @(negedge clk) begin
        if (dut.mem_write) begin
            wb_addr = {20'd0, dut.wb_widx, 2'b00};
            wb_data = dut.mem_wdata;
        end
        if (dut.mem_ready) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat);
        @(posedge clk); #1;
        cpu_write   = wr;
        cpu_read    = !wr;
        cpu_address = addr;
        cpu_wdata   = wd;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ready) break;
        end
        if (!ready) lat = -1;
    endtask

    task automatic release_req(input string tag);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(posedge clk); #1;
        chk({tag, " rdy_drop"}, 32'(ready), 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input int elat, input logic [7:0] eb,
                      input string tag);
        int lat;
        access(1'b0, addr, 32'hDEAD_DEAD, lat);
        chk({tag, " lat"}, 32'(lat), 32'(elat));
        chk({tag, " byte"}, 32'(cpu_data_out), 32'(eb));
        release_req(tag);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int elat,
                      input string tag);
        int lat;
        access(1'b1, addr, data, lat);
        chk({tag, " lat"}, 32'(lat), 32'(elat));
        release_req(tag);
    endtask

    logic [31:0] a_tab [6] = '{32'h20, 32'h40, 32'h60, 32'h80, 32'hA0, 32'hC0};
    logic [31:0] d_tab [6] = '{32'hAAAAAAAA, 32'h55555555, 32'hCAFEC0FF,
                               32'h12345678, 32'hBEEF0001, 32'h00000000};
    logic [7:0]  b_tab [6] = '{8'hAA, 8'h55, 8'hFF, 8'h78, 8'h01, 8'h00};

    initial begin
        int held;
        rst         = 1'b1;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset data", 32'(cpu_data_out), 32'd0);
        rst = 1'b0;

        rd(32'h20, 3, 8'h00, "rd20_cold");

        // 0x20 is already allocated clean by the cold read, so its write is a hit.
        for (int i = 0; i < 6; i++) begin
            wr(a_tab[i], d_tab[i], (i == 0) ? 2 : 3, $sformatf("wr%0h", a_tab[i]));
        end
        for (int i = 0; i < 6; i++) begin
            rd(a_tab[i], 2, b_tab[i], $sformatf("rd%0h", a_tab[i]));
        end

        rd(32'h61, 2, 8'hC0, "rd61");
        rd(32'h62, 2, 8'hFE, "rd62");
        rd(32'h63, 2, 8'hCA, "rd63");

        wr(32'h420, 32'h11223344, 4, "wr420_evict");
        chk("data kept after write", 32'(cpu_data_out), 32'hCA);
        chk("evict wb addr", wb_addr, 32'h20);
        chk("evict wb data", wb_data, 32'hAAAAAAAA);

        rd(32'h20, 4, 8'hAA, "rd20_refill");
        chk("refill wb addr", wb_addr, 32'h420);
        chk("refill wb data", wb_data, 32'h11223344);
        rd(32'h423, 3, 8'h11, "rd423_mem");

        begin
            int lat;
            rdy_cnt = 0;
            access(1'b0, 32'h820, 32'h0, lat);
            chk("held lat", 32'(lat), 32'd3);
            held = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (ready) held++;
            end
            chk("held ready cycles", 32'(held), 32'd5);
            chk("held mem accesses", 32'(rdy_cnt), 32'd1);
            chk("held byte", 32'(cpu_data_out), 32'h00);
            release_req("held");
        end

        rd(32'h61, 2, 8'hC0, "rd61_again");

        @(posedge clk); #1;
        cpu_read    = 1'b1;
        cpu_address = 32'hE0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in allocate ready", 32'(ready), 32'd0);
        rst      = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk); #1;
        chk("abort ready", 32'(ready), 32'd0);
        chk("abort data", 32'(cpu_data_out), 32'd0);
        rst = 1'b0;

        rd(32'h60, 3, 8'h00, "rd60_post_rst");
        rd(32'h20, 3, 8'h00, "rd20_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
